// File: rtl/seq_det_scheduler.sv
// seq_det_scheduler: round-robin sharing of one serial pattern detector among N frame requesters
// Ports:
//   Clk, Rst      clock and synchronous active-high reset
//   req, req_data requester frames (frame i at [i*FRAME_W +: FRAME_W]), held until gnt
//   gnt           one-hot 1-cycle grant; winner's frame captured that cycle
//   busy          high while a frame is in flight
//   det_w,det_rst serial bit and reset driven into the shared detector
//   det_z         registered hit flag returned by the detector
//   done,done_id,hit_count  1-cycle result pulse with requester id and hit count
module seq_det_scheduler #(
  parameter int N = 4,
  parameter int FRAME_W = 8,
  parameter int ID_W = 2,
  parameter int CNT_W = 4
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [N-1:0]         req,
  input  logic [N*FRAME_W-1:0] req_data,
  output logic [N-1:0]         gnt,
  output logic                 busy,
  output logic                 det_w,
  output logic                 det_rst,
  input  logic                 det_z,
  output logic                 done,
  output logic [ID_W-1:0]      done_id,
  output logic [CNT_W-1:0]     hit_count
);
  localparam int KW = FRAME_W > 1 ? $clog2(FRAME_W) : 1;
  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, REPORT} state_t;
  state_t state, state_n;
  logic [FRAME_W-1:0] sr;
  logic [ID_W-1:0] ptr, cur_id, win;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic [KW-1:0] k;
  logic found, grant;
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int i = 1; i <= N; i++)
      if (!found && req[(int'(ptr) + i) % N]) begin
        found = 1'b1;
        win = ID_W'((int'(ptr) + i) % N);
      end
  end
  // Outputs are gated by Rst so a mid-frame reset takes effect in the same cycle.
  always_comb begin
    grant = !Rst && state == IDLE && found;
    gnt = grant ? N'(1) << win : '0;
    state_n = state == IDLE ? (found ? CLEAR : IDLE) :
              state == CLEAR ? SHIFT :
              state == SHIFT ? (k == KW'(FRAME_W - 1) ? DRAIN : SHIFT) :
              state == DRAIN ? REPORT : IDLE;
    busy = !Rst && state != IDLE;
    det_w = !Rst && state == SHIFT && sr[FRAME_W-1];
    det_rst = Rst || state == CLEAR;
    done = !Rst && state == REPORT;
    cnt_inc = (det_z && cnt != CNT_W'(FRAME_W)) ? cnt + 1'b1 : cnt;
  end
  // Result registers load at the end of DRAIN (folding in the last-bit hit) so they
  // are valid during REPORT and hold until the next one.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      ptr <= ID_W'(N - 1);
      cur_id <= '0;
      sr <= '0;
      cnt <= '0;
      k <= '0;
      done_id <= '0;
      hit_count <= '0;
    end else begin
      state <= state_n;
      if (grant) begin
        sr <= req_data[win*FRAME_W +: FRAME_W];
        cur_id <= win;
        ptr <= win;
      end
      if (state == CLEAR) begin
        cnt <= '0;
        k <= '0;
      end
      if (state == SHIFT) begin
        sr <= sr << 1;
        k <= k + 1'b1;
        if (k != '0) cnt <= cnt_inc;
      end
      if (state == DRAIN) begin
        done_id <= cur_id;
        hit_count <= cnt_inc;
      end
    end
  end
endmodule

// File: tb/tb_seq_det_scheduler.sv
// tb_seq_det_scheduler: self-checking bench for seq_det_scheduler with a 1001 detector model
module tb_seq_det_scheduler;
  localparam int N = 4;
  logic Clk = 1'b0, Rst = 1'b1;
  logic [3:0] req = '0;
  logic [31:0] req_data = '0;
  logic [3:0] gnt, hit_count;
  logic busy, det_w, det_rst, det_z, done;
  logic [1:0] done_id;
  always #5 Clk = ~Clk;
  seq_det_scheduler #(.N(4), .FRAME_W(8), .ID_W(2), .CNT_W(4)) dut (
    .Clk(Clk), .Rst(Rst), .req(req), .req_data(req_data), .gnt(gnt), .busy(busy),
    .det_w(det_w), .det_rst(det_rst), .det_z(det_z), .done(done), .done_id(done_id),
    .hit_count(hit_count));
  logic [3:0] hist;
  always_ff @(posedge Clk)
    if (det_rst) begin
      hist <= '0;
      det_z <= 1'b0;
    end else begin
      hist <= {hist[2:0], det_w};
      det_z <= ({hist[2:0], det_w} == 4'b1001);
    end
  typedef struct {int id; int hits; int g; logic [7:0] frame;} job_t;
  typedef struct {int id; logic [7:0] frame; int hits;} vec_t;
  job_t q[$];
  int glog[$], gcyc[$], hlog[$];
  int tests = 0, fails = 0, cyc = 0, ptr_m = N - 1, free = 0, last_d = 0;
  bit autodrop = 1'b1;
  logic [3:0] gseen = '0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask
  function automatic int hits_of(input logic [7:0] f);
    int h = 0;
    for (int i = 3; i < 8; i++) if (f[10-i -: 4] == 4'b1001) h++;
    return h;
  endfunction
  task automatic sample();
    int w, jg;
    logic [3:0] eg;
    logic ew, erst;
    eg = '0;
    w = 0;
    if (Rst) begin
      q.delete();
      ptr_m = N - 1;
      free = cyc + 1;
      chk("rst_gnt", gnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_det_rst", det_rst, 1);
      chk("rst_det_w", det_w, 0);
    end else begin
      chk("busy", busy, cyc < free);
      if (cyc >= free && req != 0) begin
        for (int i = 1; i <= N; i++) begin
          w = (ptr_m + i) % N;
          if (req[w]) break;
        end
        eg = 4'(1 << w);
        ptr_m = w;
        free = cyc + 12;
        q.push_back('{w, hits_of(req_data[w*8 +: 8]), cyc, req_data[w*8 +: 8]});
      end
      chk("gnt", gnt, eg);
      for (int i = 0; i < N; i++) if (gnt[i]) begin glog.push_back(i); gcyc.push_back(cyc); end
      ew = 1'b0;
      erst = 1'b0;
      if (q.size() > 0) begin
        jg = q[0].g;
        erst = (cyc == jg + 1);
        if (cyc >= jg + 2 && cyc <= jg + 9) ew = q[0].frame[7-(cyc-jg-2)];
      end
      chk("det_w", det_w, ew);
      chk("det_rst", det_rst, erst);
      if (q.size() > 0 && cyc == q[0].g + 11) begin
        chk("done", done, 1);
        chk("done_id", done_id, q[0].id);
        chk("hit_count", hit_count, q[0].hits);
        hlog.push_back(int'(hit_count));
        last_d = cyc;
        void'(q.pop_front());
      end else chk("done", done, 0);
    end
    gseen = gnt;
    cyc++;
  endtask
  task automatic step();
    @(negedge Clk);
    sample();
    @(posedge Clk);
    #1;
    if (autodrop) req = req & ~gseen;
  endtask
  task automatic wait_done(input int n);
    int target;
    target = hlog.size() + n;
    for (int i = 0; i < 200 && hlog.size() < target; i++) step();
    chk("done_timeout", hlog.size(), target);
  endtask
  task automatic wait_grants(input int n);
    for (int i = 0; i < 200 && glog.size() < n; i++) step();
    chk("grant_timeout", glog.size(), n);
  endtask
  vec_t tv[8];
  initial begin
    int nd, n2;
    logic [3:0] m;
    tv[0] = '{0, 8'h92, 2}; tv[1] = '{1, 8'h99, 2}; tv[2] = '{2, 8'h00, 0}; tv[3] = '{3, 8'hFF, 0};
    tv[4] = '{0, 8'h09, 1}; tv[5] = '{1, 8'h49, 2}; tv[6] = '{2, 8'h93, 2}; tv[7] = '{3, 8'h80, 0};
    req = 4'hF;
    repeat (3) step();
    chk("rst_done_id", done_id, 0);
    chk("rst_hit_count", hit_count, 0);
    Rst = 1'b0;
    req = 4'b0001;
    req_data[7:0] = 8'h92;
    wait_done(1);
    chk("t2_id", glog[$], 0);
    chk("t2_lat", last_d - gcyc[$], 11);
    chk("t2_hits", hlog[$], 2);
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    glog.delete(); gcyc.delete(); hlog.delete();
    req = 4'hF;
    req_data = {8'h92, 8'hFF, 8'h00, 8'h99};
    wait_done(4);
    for (int i = 0; i < 4; i++) chk("t3_order", glog[i], i);
    for (int i = 1; i < 4; i++) chk("t3_spacing", gcyc[i] - gcyc[i-1], 12);
    chk("t3_h0", hlog[0], 2); chk("t3_h1", hlog[1], 0);
    chk("t3_h2", hlog[2], 0); chk("t3_h3", hlog[3], 2);
    for (int t = 0; t < 8; t++) begin
      req = 4'(1 << tv[t].id);
      req_data[tv[t].id*8 +: 8] = tv[t].frame;
      wait_done(1);
      chk("tv_id", done_id, tv[t].id);
      chk("tv_hits", hlog[$], tv[t].hits);
      chk("tv_lat", last_d - gcyc[$], 11);
    end
    glog.delete();
    autodrop = 1'b0;
    req = 4'b1010;
    wait_grants(4);
    repeat (3) step();
    req = 4'b1011;
    wait_grants(5);
    req = '0;
    autodrop = 1'b1;
    repeat (15) step();
    chk("t4_g0", glog[0], 1); chk("t4_g1", glog[1], 3); chk("t4_g2", glog[2], 1);
    chk("t4_g3", glog[3], 3); chk("t4_g4", glog[4], 0);
    glog.delete();
    req = 4'b0001;
    req_data[7:0] = 8'h99;
    wait_grants(1);
    repeat (5) step();
    nd = hlog.size();
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    repeat (14) step();
    chk("t5_no_done", hlog.size(), nd);
    req = 4'b0001;
    req_data[7:0] = 8'h49;
    wait_done(1);
    chk("t5_id", done_id, 0);
    chk("t5_hits", hlog[$], 2);
    glog.delete();
    req = 4'b0001;
    req_data[7:0] = 8'h93;
    wait_grants(1);
    req = req | 4'b0100;
    repeat (3) step();
    req = req & 4'b1011;
    wait_done(1);
    repeat (2) step();
    n2 = 0;
    foreach (glog[i]) if (glog[i] == 2) n2++;
    chk("t6_no_grant2", n2, 0);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) begin
        m = 4'($urandom);
        for (int i = 0; i < N; i++)
          if (m[i] && !req[i]) begin
            req_data[i*8 +: 8] = 8'($urandom);
            req[i] = 1'b1;
          end
      end
      if ($urandom_range(0, 49) == 0) req = req & 4'($urandom);
      Rst = ($urandom_range(0, 299) == 0);
      step();
    end
    Rst = 1'b0;
    repeat (15) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
